// File: rtl/pipe_controller.sv
// pipe_controller: control and hazard unit for a 5-stage pipelined ARM datapath.
//
// Decodes the Decode-stage instruction and carries its control bits through
// D->E->M->W, evaluates condition codes against an internal NZCV register in
// Execute, and produces stall/flush/forwarding selects from the datapath's
// register-match signals.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   InstrD                Decode-stage instruction
//   ALUFlags              NZCV from the ALU (Execute)
//   Match_*               register-match strobes from the datapath
//   RegSrcD, ImmSrcD      Decode-stage operand/immediate selects
//   ALUSrcE, ALUControlE  Execute-stage ALU controls
//   BranchTakenE          taken branch, redirect PC to ALUResultE
//   MemWriteM             data-memory write enable
//   MemtoRegW, RegWriteW  writeback result select / regfile write enable
//   PCSrcW                writeback targets R15
//   StallF, StallD        hold PC / hold InstrD
//   FlushD, FlushE        clear InstrD / clear the E-stage registers
//   ForwardAE, ForwardBE  00 RD1E/RD2E, 01 ResultW, 10 ALUOutM
//   StallCount            cycles with StallD=1 (PIPE_PERF_EN builds only)
//   FlushCount            cycles with FlushE=1 (PIPE_PERF_EN builds only)
//
// Build option: define PIPE_PERF_EN to include the saturating performance
// counters; otherwise both count ports are tied to zero.
module pipe_controller #(
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      InstrD,
    input  logic [3:0]       ALUFlags,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    output logic [1:0]       RegSrcD,
    output logic [1:0]       ImmSrcD,
    output logic             ALUSrcE,
    output logic [2:0]       ALUControlE,
    output logic             BranchTakenE,
    output logic             MemWriteM,
    output logic             MemtoRegW,
    output logic             RegWriteW,
    output logic             PCSrcW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [2:0] alucontrol;
        logic       flagwrite;
        logic [3:0] cond;
    } ctrl_e_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       unused_instr_bits;

    assign op    = InstrD[27:26];
    assign funct = InstrD[25:20];
    assign cmd   = InstrD[24:21];
    assign rd    = InstrD[15:12];
    assign unused_instr_bits = ^{InstrD[19:16], InstrD[11:0]};

    logic       regwrite_d;
    logic       memtoreg_d;
    logic       memwrite_d;
    logic       branch_d;
    logic       alusrc_d;
    logic       flagwrite_d;
    logic       pcsrc_d;
    logic [2:0] alucontrol_d;
    logic [1:0] regsrc_d;

    always_comb begin
        regwrite_d   = 1'b0;
        memtoreg_d   = 1'b0;
        memwrite_d   = 1'b0;
        branch_d     = 1'b0;
        alusrc_d     = 1'b0;
        flagwrite_d  = 1'b0;
        alucontrol_d = 3'b000;
        regsrc_d     = 2'b00;
        case (op)
            2'b00: begin
                alusrc_d    = funct[5];
                flagwrite_d = funct[0];
                regwrite_d  = 1'b1;
                case (cmd)
                    4'b0100: alucontrol_d = 3'b000;
                    4'b0010: alucontrol_d = 3'b001;
                    4'b0000: alucontrol_d = 3'b010;
                    4'b1100: alucontrol_d = 3'b011;
                    4'b1010: begin
                        alucontrol_d = 3'b001;
                        regwrite_d   = 1'b0;
                        flagwrite_d  = 1'b1;
                    end
                    default: begin
                        alusrc_d    = 1'b0;
                        flagwrite_d = 1'b0;
                        regwrite_d  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                alusrc_d     = 1'b1;
                alucontrol_d = funct[3] ? 3'b000 : 3'b001;
                regwrite_d   = funct[0];
                memtoreg_d   = funct[0];
                memwrite_d   = ~funct[0];
                regsrc_d[1]  = ~funct[0];
            end
            2'b10: begin
                branch_d    = 1'b1;
                alusrc_d    = 1'b1;
                regsrc_d[0] = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcsrc_d = regwrite_d & (rd == 4'hF);
    assign RegSrcD = regsrc_d;
    assign ImmSrcD = op;

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;
    logic [3:0] flags_q;
    logic       cond_ex;
    logic       ldr_stall;
    logic       pc_wr_pend;

    assign e_d = '{pcsrc: pcsrc_d, regwrite: regwrite_d, memtoreg: memtoreg_d,
                   memwrite: memwrite_d, branch: branch_d, alusrc: alusrc_d,
                   alucontrol: alucontrol_d, flagwrite: flagwrite_d,
                   cond: InstrD[31:28]};

    // The D->E register is never stalled: a load-use hazard inserts a bubble
    // here while InstrD is held upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) e_q <= '0;
        else       e_q <= FlushE ? '0 : e_d;
    end

    // flags_q is {N, Z, C, V}
    always_comb begin
        case (e_q.cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = flags_q[3] == flags_q[0];
            4'b1011: cond_ex = flags_q[3] != flags_q[0];
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // No bypass: an instruction right behind a flag-setting one sees the
    // updated flags only from the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           flags_q <= RESET_FLAGS;
        else if (e_q.flagwrite && cond_ex)   flags_q <= ALUFlags;
    end

    assign m_d = '{pcsrc: e_q.pcsrc & cond_ex, regwrite: e_q.regwrite & cond_ex,
                   memtoreg: e_q.memtoreg, memwrite: e_q.memwrite & cond_ex};
    assign w_d = '{pcsrc: m_q.pcsrc, regwrite: m_q.regwrite, memtoreg: m_q.memtoreg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign ALUSrcE      = e_q.alusrc;
    assign ALUControlE  = e_q.alucontrol;
    assign BranchTakenE = e_q.branch & cond_ex;
    assign MemWriteM    = m_q.memwrite;
    assign MemtoRegW    = w_q.memtoreg;
    assign RegWriteW    = w_q.regwrite;
    assign PCSrcW       = w_q.pcsrc;

    assign ForwardAE = (Match_1E_M & m_q.regwrite) ? 2'b10 :
                       (Match_1E_W & w_q.regwrite) ? 2'b01 : 2'b00;
    assign ForwardBE = (Match_2E_M & m_q.regwrite) ? 2'b10 :
                       (Match_2E_W & w_q.regwrite) ? 2'b01 : 2'b00;

    // A PC write in flight (D, E or M) freezes fetch until it retires in W.
    assign ldr_stall  = Match_12D_E & e_q.memtoreg;
    assign pc_wr_pend = pcsrc_d | e_q.pcsrc | m_q.pcsrc;
    assign StallF     = ldr_stall | pc_wr_pend;
    assign StallD     = ldr_stall;
    assign FlushD     = pc_wr_pend | w_q.pcsrc | BranchTakenE;
    assign FlushE     = ldr_stall | BranchTakenE;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (FlushE && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
